// File: rtl/ex_muldiv_unit_pkg.sv
// ex_muldiv_unit_pkg: shared opcode/funct constants, FSM encodings and operand-signedness helpers for the EX mul/div engine
package ex_muldiv_unit_pkg;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;
  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;
  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_BUSY    = 2'd1;
  localparam logic [1:0] S_DONE    = 2'd2;
  function automatic logic signed_a(input logic [2:0] f3);
    return f3[2] ? ~f3[0] : (f3[1:0] != 2'b11);
  endfunction
  function automatic logic signed_b(input logic [2:0] f3);
    return f3[2] ? ~f3[0] : ~f3[1];
  endfunction
endpackage

// File: rtl/muldiv_div_step.sv
// muldiv_div_step: one combinational restoring-division step (rem_i,bit_i shifted in, divisor div_i -> rem_o, q_o)
module muldiv_div_step #(
  parameter int W = 32
) (
  input  logic [W-1:0] rem_i,
  input  logic [W-1:0] div_i,
  input  logic         bit_i,
  output logic [W-1:0] rem_o,
  output logic         q_o
);
  logic [W:0] diff;
  assign diff  = {rem_i, bit_i} - {1'b0, div_i};
  assign q_o   = ~diff[W];
  assign rem_o = q_o ? diff[W-1:0] : {rem_i[W-2:0], bit_i};
endmodule

// File: rtl/ex_muldiv_unit.sv
// ex_muldiv_unit: multi-cycle RV32M mul/div engine; ports: clk/rst/flush, ID/EX fields (opcode/funct7/funct3/rs1/rs2/rd) in, stall/busy/result/rd write-back out; MULDIV_FAST_MUL_EN selects single-cycle multiply
module ex_muldiv_unit
  import ex_muldiv_unit_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int RD_W = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic [6:0]      opcode_i,
  input  logic [6:0]      funct7_i,
  input  logic [2:0]      funct3_i,
  input  logic [XLEN-1:0] rs1_data_i,
  input  logic [XLEN-1:0] rs2_data_i,
  input  logic            rd_we_i,
  input  logic [RD_W-1:0] rd_addr_i,
  output logic            stall_o,
  output logic            busy_o,
  output logic [XLEN-1:0] result_o,
  output logic            result_valid_o,
  output logic            rd_we_o,
  output logic [RD_W-1:0] rd_addr_o
);
  localparam int CW = $clog2(XLEN);
  localparam logic [XLEN-1:0] MIN = {1'b1, {(XLEN-1){1'b0}}};
  logic [1:0] state_q, state_d;
  logic [CW-1:0] cnt_q;
  logic [2*XLEN-1:0] acc_q, acc_d, step, raw, fix;
  logic [XLEN-1:0] m_q, result_q, result_d, a_mag, b_mag, fast_res, div_fast, res_slow, rem_n;
  logic [XLEN:0] sum;
  logic [2:0] f3_q;
  logic neg_q, rd_we_q, start, div_op, sa, sb, div_zero, div_ovf, fast, q_bit;
  logic [RD_W-1:0] rd_addr_q;
  assign start    = state_q == S_IDLE && opcode_i == OP_R && funct7_i == F7_MULDIV && !flush;
  assign div_op   = funct3_i[2];
  assign sa       = signed_a(funct3_i) & rs1_data_i[XLEN-1];
  assign sb       = signed_b(funct3_i) & rs2_data_i[XLEN-1];
  assign a_mag    = sa ? -rs1_data_i : rs1_data_i;
  assign b_mag    = sb ? -rs2_data_i : rs2_data_i;
  assign div_zero = div_op && rs2_data_i == '0;
  assign div_ovf  = div_op && !funct3_i[0] && rs1_data_i == MIN && rs2_data_i == '1;
  assign div_fast = div_zero ? (funct3_i[1] ? rs1_data_i : '1) : (funct3_i[1] ? '0 : MIN);
`ifdef MULDIV_FAST_MUL_EN
  logic [2*XLEN-1:0] fprod;
  assign fprod    = {{XLEN{sa}}, rs1_data_i} * {{XLEN{sb}}, rs2_data_i};
  assign fast     = div_zero | div_ovf | !div_op;
  assign fast_res = div_op ? div_fast : funct3_i == F3_MUL ? fprod[XLEN-1:0] : fprod[2*XLEN-1:XLEN];
`else
  assign fast     = div_zero | div_ovf;
  assign fast_res = div_fast;
`endif
  muldiv_div_step #(.W(XLEN)) u_div_step (
    .rem_i (acc_q[2*XLEN-1:XLEN]),
    .div_i (m_q),
    .bit_i (acc_q[XLEN-1]),
    .rem_o (rem_n),
    .q_o   (q_bit)
  );
  // Multiply keeps {partial_hi, multiplier} in acc; divide keeps {remainder, dividend/quotient}.
  assign sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, m_q} : '0);
  assign step = f3_q[2] ? {rem_n, acc_q[XLEN-2:0], q_bit} : {sum, acc_q[XLEN-1:1]};
  always_comb begin
    state_d  = flush ? S_IDLE :
               state_q == S_IDLE ? (start ? (fast ? S_DONE : S_BUSY) : S_IDLE) :
               state_q == S_BUSY ? (cnt_q == '0 ? S_DONE : S_BUSY) : S_IDLE;
    acc_d    = start ? {{XLEN{1'b0}}, div_op ? a_mag : b_mag} : state_q == S_BUSY ? step : acc_q;
    // Sign fix-up uses the final accumulator so the result is ready on the edge into DONE.
    raw      = f3_q[2] ? {{XLEN{1'b0}}, f3_q[1] ? acc_d[2*XLEN-1:XLEN] : acc_d[XLEN-1:0]} : acc_d;
    fix      = neg_q ? -raw : raw;
    res_slow = (f3_q[2] || f3_q[1:0] == 2'b00) ? fix[XLEN-1:0] : fix[2*XLEN-1:XLEN];
    result_d = state_d == S_DONE ? (state_q == S_IDLE ? fast_res : res_slow) : result_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      m_q       <= '0;
      f3_q      <= '0;
      neg_q     <= 1'b0;
      rd_we_q   <= 1'b0;
      rd_addr_q <= '0;
      result_q  <= '0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      result_q <= result_d;
      cnt_q    <= start ? CW'(XLEN-1) : state_q == S_BUSY ? cnt_q - 1'b1 : cnt_q;
      if (start) begin
        m_q       <= div_op ? b_mag : a_mag;
        f3_q      <= funct3_i;
        neg_q     <= (div_op && funct3_i[1]) ? sa : sa ^ sb;
        rd_we_q   <= rd_we_i;
        rd_addr_q <= rd_addr_i;
      end
    end
  end
  assign stall_o        = start | state_q == S_BUSY;
  assign busy_o         = state_q != S_IDLE;
  assign result_valid_o = state_q == S_DONE && !flush;
  assign rd_we_o        = rd_we_q & result_valid_o;
  assign rd_addr_o      = rd_addr_q;
  assign result_o       = result_q;
endmodule

// File: tb/tb_ex_muldiv_unit.sv
// tb_ex_muldiv_unit: directed self-checking bench for ex_muldiv_unit
module tb_ex_muldiv_unit;
  import ex_muldiv_unit_pkg::*;
`ifdef MULDIV_FAST_MUL_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = 33;
`endif
  typedef struct packed {logic [2:0] f3; logic [31:0] a; logic [31:0] b; logic [31:0] r;} op_t;
  logic clk = 1'b0, rst, flush, rd_we;
  logic [6:0] opcode, funct7;
  logic [2:0] funct3;
  logic [31:0] rs1, rs2;
  logic [4:0] rd_addr;
  logic stall_o, busy_o, result_valid_o, rd_we_o;
  logic [31:0] result_o;
  logic [4:0] rd_addr_o;
  int vec = 0, errs = 0;
  ex_muldiv_unit #(.XLEN(32), .RD_W(5)) dut (
    .clk(clk), .rst(rst), .flush(flush), .opcode_i(opcode), .funct7_i(funct7), .funct3_i(funct3),
    .rs1_data_i(rs1), .rs2_data_i(rs2), .rd_we_i(rd_we), .rd_addr_i(rd_addr),
    .stall_o(stall_o), .busy_o(busy_o), .result_o(result_o), .result_valid_o(result_valid_o),
    .rd_we_o(rd_we_o), .rd_addr_o(rd_addr_o)
  );
  always #5 clk = ~clk;
  task automatic drive(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
    opcode = OP_R; funct7 = F7_MULDIV; funct3 = f3; rs1 = a; rs2 = b; rd_we = 1'b1; rd_addr = rd;
  endtask
  task automatic idle_in();
    opcode = 7'd0; funct7 = 7'd0; funct3 = 3'd0; rd_we = 1'b0; rd_addr = 5'd0;
  endtask
  task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd,
                        output int lat, output int stl, output logic [31:0] res, output logic we, output logic [4:0] ra);
    drive(f3, a, b, rd);
    lat = -1; stl = 0; res = '0; we = 1'b0; ra = '0;
    for (int k = 0; k < 64 && lat < 0; k++) begin
      @(negedge clk);
      stl += int'(stall_o);
      if (result_valid_o) begin lat = k; res = result_o; we = rd_we_o; ra = rd_addr_o; end
      @(posedge clk); #1;
      idle_in();
    end
  endtask
  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; rs1 = '0; rs2 = '0; idle_in();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    vec++; if ({stall_o, busy_o, result_valid_o, rd_we_o} !== 4'b0) begin errs++; $display("FAIL reset_ctl: got %b expected 0000", {stall_o, busy_o, result_valid_o, rd_we_o}); end
    vec++; if ({result_o, rd_addr_o} !== 37'd0) begin errs++; $display("FAIL reset_data: got %h expected 0", {result_o, rd_addr_o}); end
    @(posedge clk); #1;
  endtask
  task automatic test_mul();
    int lat, stl; logic [31:0] res; logic we; logic [4:0] ra;
    run_op(F3_MUL, 32'd7, 32'hFFFFFFFD, 5'd5, lat, stl, res, we, ra);
    vec++; if (res !== 32'hFFFFFFEB) begin errs++; $display("FAIL mul_res: got %h expected ffffffeb", res); end
    vec++; if (lat !== MUL_LAT) begin errs++; $display("FAIL mul_lat: got %0d expected %0d", lat, MUL_LAT); end
    vec++; if (stl !== MUL_LAT) begin errs++; $display("FAIL mul_stall: got %0d expected %0d", stl, MUL_LAT); end
    vec++; if ({we, ra} !== {1'b1, 5'd5}) begin errs++; $display("FAIL mul_rd: got we=%b addr=%0d expected we=1 addr=5", we, ra); end
    @(negedge clk);
    vec++; if ({result_valid_o, result_o} !== {1'b0, 32'hFFFFFFEB}) begin errs++; $display("FAIL mul_hold: got v=%b %h expected v=0 ffffffeb", result_valid_o, result_o); end
    @(posedge clk); #1;
    run_op(F3_MUL, 32'h12345678, 32'h10, 5'd0, lat, stl, res, we, ra);
    vec++; if ({res, we, ra} !== {32'h23456780, 1'b1, 5'd0}) begin errs++; $display("FAIL mul_x0: got %h we=%b addr=%0d expected 23456780 we=1 addr=0", res, we, ra); end
  endtask
  task automatic test_mul_high();
    op_t t[5];
    int lat, stl; logic [31:0] res; logic we; logic [4:0] ra;
    t = '{'{F3_MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE},
          '{F3_MULH, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000},
          '{F3_MULHSU, 32'hFFFFFFFF, 32'd2, 32'hFFFFFFFF},
          '{F3_MULH, 32'h80000000, 32'h80000000, 32'h40000000},
          '{F3_MULHU, 32'h80000000, 32'd4, 32'h00000002}};
    for (int i = 0; i < 5; i++) begin
      run_op(t[i].f3, t[i].a, t[i].b, 5'd3, lat, stl, res, we, ra);
      vec++; if (res !== t[i].r) begin errs++; $display("FAIL mulh[%0d]: got %h expected %h", i, res, t[i].r); end
      vec++; if (lat !== MUL_LAT) begin errs++; $display("FAIL mulh_lat[%0d]: got %0d expected %0d", i, lat, MUL_LAT); end
    end
  endtask
  task automatic test_div();
    op_t t[4];
    int lat, stl; logic [31:0] res; logic we; logic [4:0] ra;
    t = '{'{F3_DIV, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD},
          '{F3_REM, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF},
          '{F3_DIVU, 32'd100, 32'd7, 32'd14},
          '{F3_REMU, 32'd100, 32'd7, 32'd2}};
    for (int i = 0; i < 4; i++) begin
      run_op(t[i].f3, t[i].a, t[i].b, 5'd9, lat, stl, res, we, ra);
      vec++; if (res !== t[i].r) begin errs++; $display("FAIL div[%0d]: got %h expected %h", i, res, t[i].r); end
      vec++; if ({lat, stl} !== {32'd33, 32'd33}) begin errs++; $display("FAIL div_timing[%0d]: got lat=%0d stall=%0d expected 33/33", i, lat, stl); end
    end
  endtask
  task automatic test_fast_paths();
    op_t t[6];
    int lat, stl; logic [31:0] res; logic we; logic [4:0] ra;
    t = '{'{F3_DIVU, 32'd5, 32'd0, 32'hFFFFFFFF},
          '{F3_REMU, 32'd5, 32'd0, 32'd5},
          '{F3_DIV, 32'h80000000, 32'hFFFFFFFF, 32'h80000000},
          '{F3_REM, 32'h80000000, 32'hFFFFFFFF, 32'd0},
          '{F3_DIV, 32'hFFFFFFFB, 32'd0, 32'hFFFFFFFF},
          '{F3_REM, 32'hFFFFFFFB, 32'd0, 32'hFFFFFFFB}};
    for (int i = 0; i < 6; i++) begin
      run_op(t[i].f3, t[i].a, t[i].b, 5'd7, lat, stl, res, we, ra);
      vec++; if (res !== t[i].r) begin errs++; $display("FAIL fast[%0d]: got %h expected %h", i, res, t[i].r); end
      vec++; if ({lat, stl} !== {32'd1, 32'd1}) begin errs++; $display("FAIL fast_timing[%0d]: got lat=%0d stall=%0d expected 1/1", i, lat, stl); end
    end
  endtask
  task automatic test_flush_busy();
    int lat, stl; logic [31:0] res; logic we; logic [4:0] ra;
    drive(F3_DIV, 32'd1000, 32'd3, 5'd4);
    @(negedge clk);
    @(posedge clk); #1 idle_in();
    repeat (9) @(posedge clk);
    #1 flush = 1'b1;
    @(negedge clk);
    vec++; if ({stall_o, result_valid_o} !== 2'b10) begin errs++; $display("FAIL flush_t10: got stall=%b valid=%b expected 1/0", stall_o, result_valid_o); end
    @(posedge clk); #1 flush = 1'b0;
    @(negedge clk);
    vec++; if ({stall_o, busy_o, result_valid_o} !== 3'b000) begin errs++; $display("FAIL flush_t11: got %b expected 000", {stall_o, busy_o, result_valid_o}); end
    @(posedge clk); #1;
    run_op(F3_MUL, 32'd7, 32'hFFFFFFFD, 5'd6, lat, stl, res, we, ra);
    vec++; if ({res, ra} !== {32'hFFFFFFEB, 5'd6}) begin errs++; $display("FAIL flush_next_mul: got %h addr=%0d expected ffffffeb addr=6", res, ra); end
    vec++; if (lat !== MUL_LAT) begin errs++; $display("FAIL flush_next_lat: got %0d expected %0d", lat, MUL_LAT); end
  endtask
  task automatic test_flush_idle();
    drive(F3_DIVU, 32'd9, 32'd2, 5'd1);
    flush = 1'b1;
    @(negedge clk);
    vec++; if (stall_o !== 1'b0) begin errs++; $display("FAIL flush_idle_stall: got %b expected 0", stall_o); end
    @(posedge clk); #1 flush = 1'b0; idle_in();
    @(negedge clk);
    vec++; if ({busy_o, stall_o} !== 2'b00) begin errs++; $display("FAIL flush_idle_busy: got %b expected 00", {busy_o, stall_o}); end
    @(posedge clk); #1;
  endtask
  task automatic test_flush_done();
    drive(F3_DIVU, 32'd100, 32'd7, 5'd2);
    @(negedge clk);
    @(posedge clk); #1 idle_in();
    repeat (32) @(posedge clk);
    #1 flush = 1'b1;
    @(negedge clk);
    vec++; if ({busy_o, result_valid_o, rd_we_o} !== 3'b100) begin errs++; $display("FAIL flush_done: got busy/valid/we=%b expected 100", {busy_o, result_valid_o, rd_we_o}); end
    @(posedge clk); #1 flush = 1'b0;
    @(negedge clk);
    vec++; if ({busy_o, result_valid_o} !== 2'b00) begin errs++; $display("FAIL flush_done_after: got %b expected 00", {busy_o, result_valid_o}); end
    @(posedge clk); #1;
  endtask
  task automatic test_reset_mid();
    int pulses = 0;
    drive(F3_MUL, 32'd7, 32'hFFFFFFFD, 5'd5);
    @(negedge clk);
    @(posedge clk); #1 idle_in();
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    vec++; if ({stall_o, busy_o, result_o, result_valid_o, rd_we_o, rd_addr_o} !== 41'd0) begin errs++; $display("FAIL reset_mid: got %h expected 0", {stall_o, busy_o, result_o, result_valid_o, rd_we_o, rd_addr_o}); end
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      pulses += int'(result_valid_o);
    end
    vec++; if (pulses !== 0) begin errs++; $display("FAIL reset_mid_pulse: got %0d pulses expected 0", pulses); end
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  initial begin
    test_reset();
    test_mul();
    test_mul_high();
    test_div();
    test_fast_paths();
    test_flush_busy();
    test_flush_idle();
    test_flush_done();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end
endmodule

// File: doc/ex_muldiv_unit.md
Name: ex_muldiv_unit

Overview:
- Multi-cycle RV32M multiply/divide engine in the EX stage; consumes the decoded fields registered by the ID/EX pipeline register.
- Drives the stall request back to the front end and to ID/EX; ID/EX inserts bubbles while the stall is high.
- Captures operands on the start cycle, iterates, then presents a one-cycle result with rd write-back info to the EX/MEM path.

Parameters:
- XLEN, 32, operand/result width (only 32 supported).
- RD_W, 5, destination register address width.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- flush  in  1  pipeline flush; aborts any operation in progress.
- opcode_i  in  7  opcode from ID/EX.
- funct7_i  in  7  funct7 from ID/EX.
- funct3_i  in  3  funct3 from ID/EX.
- rs1_data_i  in  XLEN  operand A.
- rs2_data_i  in  XLEN  operand B.
- rd_we_i  in  1  destination write enable from ID/EX.
- rd_addr_i  in  RD_W  destination register address.
- stall_o  out  1  stall request to PC, IF/ID and ID/EX.
- busy_o  out  1  state != IDLE.
- result_o  out  XLEN  operation result.
- result_valid_o  out  1  result_o valid this cycle (one-cycle pulse).
- rd_we_o  out  1  captured rd_we AND result_valid_o.
- rd_addr_o  out  RD_W  captured rd address.

Behaviour:
- Reset: rst is synchronous, active-high; clock is clk. All outputs are 0 and the state is IDLE.
- start = (state==IDLE) & (opcode_i==OP_R) & (funct7_i==F7_MULDIV) & ~flush.
  - Start is ignored in every other state.
- funct3 encodings: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- States: IDLE -> BUSY -> DONE -> IDLE.
  - IDLE -> DONE directly for the fast paths.
- Start cycle T:
  - Latch operands, funct3, rd_we and rd_addr.
  - Latch operand signs and magnitudes. Signed operands are converted to absolute values; MULHSU treats rs2 as unsigned.
  - Load iteration counter with XLEN-1.
- BUSY: T+1..T+32, one bit per cycle.
  - Multiply is shift-add into a 2*XLEN accumulator.
  - Divide is restoring division, one quotient bit per cycle.
  - Counter decrements each cycle; when the counter reaches 0, the next state is DONE.
- DONE at T+33:
  - Result sign fix-up is applied combinationally from the registered magnitudes, then registered into result_o.
  - MUL returns the low XLEN bits; MULH/MULHSU/MULHU return the high XLEN bits of the signed-corrected 2*XLEN product.
  - DIV quotient sign = sign(rs1) XOR sign(rs2); REM sign = sign(rs1).
  - result_valid_o = 1 for exactly one cycle.
  - result_o holds its value after DONE until the next DONE.
- stall_o = start | (state==BUSY). It is high from T through T+32 (33 cycles) and low in DONE.
- Fast paths (DONE at T+1, stall_o high only at T):
  - Divide by zero: quotient = all ones; remainder = rs1.
  - Signed overflow (rs1 = 0x80000000, rs2 = 0xFFFFFFFF, DIV/REM): quotient = 0x80000000; remainder = 0.
- Flush in BUSY or DONE:
  - Next state is IDLE and stall_o falls the next cycle.
  - result_valid_o and rd_we_o stay 0, suppressing a DONE pulse in the same cycle.
- Flush coincident with a valid muldiv instruction in IDLE: no capture and no stall.
- Reset mid-operation: returns to IDLE immediately with outputs cleared.
- rd_addr_o = 0 when rd is the destination: rd_we_o is still driven from the captured value; x0 is discarded by the regfile.

Optional Feature:
- MULDIV_FAST_MUL_EN defined:
  - All multiplies are computed single-cycle with a 2*XLEN-wide signed/unsigned multiply on the captured operands.
  - IDLE -> DONE at T+1; stall_o high only at T. Divides are unchanged.
- Undefined: all multiplies use the 32-cycle shift-add path above.

Decomposition:
- Shared defines header:
  - OP_R (7'b0110011) and F7_MULDIV (7'b0000001).
  - F3_MUL..F3_REMU constants.
  - State encodings for IDLE, BUSY and DONE.
- One natural sub-module: muldiv_div_step.
  - Combinational, one restoring-division step.
  - Inputs: partial remainder, divisor, next dividend bit.
  - Outputs: new remainder, quotient bit.

Test Plan:
- MUL, rs1 = 7, rs2 = 0xFFFFFFFD (-3) -> result_o = 0xFFFFFFEB; result_valid_o at T+33; stall_o high T..T+32; rd_we_o = 1 with rd_addr_o = 5.
- MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE; MULH same operands -> 0x00000000; MULHSU 0xFFFFFFFF x 2 -> 0xFFFFFFFF.
- DIV -7 / 2 -> 0xFFFFFFFD; REM -7 / 2 -> 0xFFFFFFFF; DIVU 100 / 7 -> 14; REMU 100 / 7 -> 2.
- DIVU 5 / 0 -> 0xFFFFFFFF at T+1 (stall_o only at T); REMU 5 / 0 -> 5; DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM same operands -> 0.
- Flush asserted at T+10 of a DIV -> stall_o = 0 at T+11, state IDLE, no result_valid_o pulse; a new MUL at T+12 completes normally.
- rst asserted at T+5 of a MUL -> all outputs 0 next cycle. With MULDIV_FAST_MUL_EN, MUL 7 x -3 gives 0xFFFFFFEB at T+1.
